triggered_pattern_capture: RTL and testbench

//  Triggered capture unit for NUM_SIG parallel digital inputs. Software arms it; it waits for a mask/value trigger, stores n_samples, then software reads them back one per read strobe.

---
 rtl/triggered_capture_pkg.sv | 29 ++
 rtl/capture_rate_divider.sv | 29 ++
 rtl/triggered_pattern_capture.sv | 217 +++++++++++++++++++++
 tb/tb_triggered_pattern_capture.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/triggered_capture_pkg.sv
// Shared types and helpers for the triggered pattern capture unit.
//   capture_state_t : capture FSM states, also exported on status[1:0]
//   DBG_*           : bit positions inside dbg_error
//   clamp_samples   : maps a requested shot length onto 1..max_n
package triggered_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } capture_state_t;

    localparam int DBG_DBL_RD      = 0;
    localparam int DBG_RD_OVERRUN  = 1;
    localparam int DBG_RD_NOT_DONE = 2;
    localparam int DBG_ARM_BUSY    = 3;

    function automatic logic [31:0] clamp_samples(input logic [31:0] n,
                                                  input logic [31:0] max_n);
        if (n == 32'd0)
            return 32'd1;
        else if (n > max_n)
            return max_n;
        else
            return n;
    endfunction

endpackage

// File: rtl/capture_rate_divider.sv
// Sample-rate divider: o_tick is high in the cycle the counter equals
// i_clk_div, after which the counter returns to 0. i_restart zeroes the
// counter synchronously so a new shot starts with a fresh phase.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_restart      : synchronous counter restart
//   i_clk_div      : tick period minus one
//   o_tick         : sample strobe
module capture_rate_divider (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_restart,
    input  logic [15:0] i_clk_div,
    output logic        o_tick
);

    logic [15:0] r_cnt;

    assign o_tick = (r_cnt == i_clk_div);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_restart || o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 16'd1;
    end

endmodule

// File: rtl/triggered_pattern_capture.sv
// Triggered capture of NUM_SIG parallel inputs into a NUM_SAMP-deep buffer.
// Software arms, the unit waits for a mask/value match on a divided sample
// tick, stores the shot, then replays it one sample per read strobe edge.
// Optional macro PRETRIGGER_EN adds the pre_trig port: while armed every
// tick is recorded circularly so up to pre_trig samples preceding the
// trigger are returned ahead of the trigger sample.
//   axi_clk, axi_resetn     : clock, async active-low reset
//   arm, clear              : start shot / abort (clear has priority)
//   trig_mask, trig_value   : trigger compare on masked bits
//   n_samples, clk_div      : shot length (clamped), tick period - 1
//   input_signals           : sampled inputs
//   read_channel_rdStrobe   : readout advance strobe
//   read_channel            : current readout sample
//   sample_count            : samples stored in this shot
//   trig_latency            : miss ticks spent in ARMED (saturating)
//   status                  : {trig_seen, state}
//   dbg_error               : sticky error flags
module triggered_pattern_capture
    import triggered_capture_pkg::*;
#(
    parameter int NUM_SIG  = 14,
    parameter int NUM_SAMP = 128
) (
    input  logic               axi_clk,
    input  logic               axi_resetn,
    input  logic               arm,
    input  logic               clear,
    input  logic [NUM_SIG-1:0] trig_mask,
    input  logic [NUM_SIG-1:0] trig_value,
    input  logic [31:0]        n_samples,
    input  logic [15:0]        clk_div,
`ifdef PRETRIGGER_EN
    input  logic [31:0]        pre_trig,
`endif
    input  logic [NUM_SIG-1:0] input_signals,
    input  logic               read_channel_rdStrobe,
    output logic [NUM_SIG-1:0] read_channel,
    output logic [31:0]        sample_count,
    output logic [31:0]        trig_latency,
    output logic [2:0]         status,
    output logic [31:0]        dbg_error
);

    localparam int          PTR_W = $clog2(NUM_SAMP);
    localparam logic [31:0] MAX_N = 32'(NUM_SAMP);

    capture_state_t     r_state, w_next;
    logic [NUM_SIG-1:0] r_buf [NUM_SAMP];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_base, w_rd_addr;
    logic [31:0]        r_rd_idx, r_sample_count, r_trig_latency;
    logic [31:0]        r_pre_int, r_pre_cnt, r_post, r_post_tgt;
    logic [NUM_SIG-1:0] r_read_channel;
    logic [3:0]         r_dbg;
    logic               r_trig_seen, r_rd_prev, r_first_rd;
    logic               w_tick, w_hit, w_arm_ok, w_arm_busy, w_trig, w_pre_wr;
    logic               w_cap, w_wr_en, w_rd_edge;
    logic [31:0]        w_n_clamp, w_pre_clamp;

    assign w_n_clamp = clamp_samples(n_samples, MAX_N);

`ifdef PRETRIGGER_EN
    localparam bit PRE_EN = 1'b1;
    assign w_pre_clamp = (pre_trig > w_n_clamp - 32'd1) ? w_n_clamp - 32'd1 : pre_trig;
`else
    localparam bit PRE_EN = 1'b0;
    assign w_pre_clamp = '0;
`endif

    capture_rate_divider u_div (
        .i_clk     (axi_clk),
        .i_rst_n   (axi_resetn),
        .i_restart (w_arm_ok || clear),
        .i_clk_div (clk_div),
        .o_tick    (w_tick)
    );

    assign w_hit      = (((input_signals ^ trig_value) & trig_mask) == '0);
    assign w_arm_ok   = arm && !clear && (r_state == ST_IDLE  || r_state == ST_DONE);
    assign w_arm_busy = arm && !clear && (r_state == ST_ARMED || r_state == ST_CAPTURE);
    assign w_trig     = (r_state == ST_ARMED) && w_tick && w_hit;
    // Pre-trigger history: misses are recorded too, so the window before the
    // trigger is already in the buffer when it fires.
    assign w_pre_wr   = PRE_EN && (r_state == ST_ARMED) && w_tick && !w_hit;
    assign w_cap      = (r_state == ST_CAPTURE) && w_tick;
    assign w_wr_en    = !clear && (w_trig || w_pre_wr || w_cap);
    assign w_rd_edge  = read_channel_rdStrobe && !r_rd_prev;
    assign w_rd_addr  = r_rd_base + r_rd_idx[PTR_W-1:0];

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (clear)
            w_next = ST_IDLE;
        else begin
            case (r_state)
                ST_IDLE:    if (arm) w_next = ST_ARMED;
                ST_ARMED:   if (w_trig) w_next = (r_post_tgt == 32'd1) ? ST_DONE : ST_CAPTURE;
                ST_CAPTURE: if (w_tick && (r_post + 32'd1 == r_post_tgt)) w_next = ST_DONE;
                ST_DONE:    if (arm) w_next = ST_ARMED;
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    // Buffer contents are don't-care until written, so no reset here.
    always_ff @(posedge axi_clk) begin
        if (w_wr_en)
            r_buf[r_wr_ptr] <= input_signals;
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn)
            r_rd_prev <= 1'b0;
        else
            r_rd_prev <= read_channel_rdStrobe;
    end

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_wr_ptr       <= '0;
            r_rd_base      <= '0;
            r_rd_idx       <= '0;
            r_sample_count <= '0;
            r_trig_latency <= '0;
            r_pre_int      <= '0;
            r_pre_cnt      <= '0;
            r_post         <= '0;
            r_post_tgt     <= '0;
            r_read_channel <= '0;
            r_dbg          <= '0;
            r_trig_seen    <= 1'b0;
            r_first_rd     <= 1'b0;
        end else if (clear) begin
            r_wr_ptr       <= '0;
            r_rd_idx       <= '0;
            r_sample_count <= '0;
            r_trig_latency <= '0;
            r_pre_cnt      <= '0;
            r_post         <= '0;
            r_read_channel <= '0;
            r_dbg          <= '0;
            r_trig_seen    <= 1'b0;
            r_first_rd     <= 1'b0;
        end else begin
            // The last store lands in the transition cycle, so the first
            // readout sample is fetched one cycle later.
            r_first_rd <= (r_state != ST_DONE) && (w_next == ST_DONE);

            if (w_arm_ok) begin
                r_wr_ptr       <= '0;
                r_sample_count <= '0;
                r_trig_latency <= '0;
                r_trig_seen    <= 1'b0;
                r_pre_cnt      <= '0;
                r_post         <= '0;
                r_pre_int      <= w_pre_clamp;
                r_post_tgt     <= w_n_clamp - w_pre_clamp;
            end
            if (w_arm_busy)
                r_dbg[DBG_ARM_BUSY] <= 1'b1;

            if (w_trig) begin
                r_rd_base      <= r_wr_ptr - r_pre_cnt[PTR_W-1:0];
                r_wr_ptr       <= r_wr_ptr + 1'b1;
                r_trig_seen    <= 1'b1;
                r_post         <= 32'd1;
                r_sample_count <= r_pre_cnt + 32'd1;
            end else if ((r_state == ST_ARMED) && w_tick) begin
                if (r_trig_latency != '1)
                    r_trig_latency <= r_trig_latency + 32'd1;
                if (w_pre_wr) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (r_pre_cnt < r_pre_int)
                        r_pre_cnt <= r_pre_cnt + 32'd1;
                end
            end

            if (w_cap) begin
                r_wr_ptr       <= r_wr_ptr + 1'b1;
                r_post         <= r_post + 32'd1;
                r_sample_count <= r_sample_count + 32'd1;
            end

            if (r_first_rd) begin
                r_read_channel <= r_buf[r_rd_base];
                r_rd_idx       <= 32'd1;
            end else if (w_rd_edge) begin
                if (r_state == ST_DONE) begin
                    if (r_rd_idx < r_sample_count) begin
                        r_read_channel <= r_buf[w_rd_addr];
                        r_rd_idx       <= r_rd_idx + 32'd1;
                    end else begin
                        r_read_channel         <= '0;
                        r_dbg[DBG_RD_OVERRUN]  <= 1'b1;
                    end
                end else
                    r_dbg[DBG_RD_NOT_DONE] <= 1'b1;
            end

            if (read_channel_rdStrobe && r_rd_prev)
                r_dbg[DBG_DBL_RD] <= 1'b1;
        end
    end

    assign read_channel = r_read_channel;
    assign sample_count = r_sample_count;
    assign trig_latency = r_trig_latency;
    assign status       = {r_trig_seen, r_state};
    assign dbg_error    = {28'd0, r_dbg};

endmodule

// File: tb/tb_triggered_pattern_capture.sv
module tb_triggered_pattern_capture;

    localparam int NSAMP = 128;
`ifdef PRETRIGGER_EN
    localparam bit PRE_ON = 1'b1;
    logic [31:0] pre_s = '0;
`else
    localparam bit PRE_ON = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, arm = 1'b0, clr = 1'b0, rd = 1'b0;
    logic [13:0] mask = '0, val = '0, ins = '0;
    logic [31:0] nsamp = 32'd1;
    logic [15:0] div = '0;
    logic [13:0] rdch;
    logic [31:0] scount, tlat, dbg;
    logic [2:0]  stat;

    triggered_pattern_capture #(.NUM_SIG(14), .NUM_SAMP(NSAMP)) dut (
        .axi_clk               (clk),
        .axi_resetn            (rst_n),
        .arm                   (arm),
        .clear                 (clr),
        .trig_mask             (mask),
        .trig_value            (val),
        .n_samples             (nsamp),
        .clk_div               (div),
`ifdef PRETRIGGER_EN
        .pre_trig              (pre_s),
`endif
        .input_signals         (ins),
        .read_channel_rdStrobe (rd),
        .read_channel          (rdch),
        .sample_count          (scount),
        .trig_latency          (tlat),
        .status                (stat),
        .dbg_error             (dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, fails = 0;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       nm;
    } chk_t;
    chk_t q[$];

    localparam int S_RD = 0, S_CNT = 1, S_LAT = 2, S_STAT = 3, S_DBG = 4;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            S_RD:    return 32'(rdch);
            S_CNT:   return scount;
            S_LAT:   return tlat;
            S_STAT:  return 32'(stat);
            default: return dbg;
        endcase
    endfunction

    // Monitor: compares every queued expectation whose cycle has come.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            chk_t c;
            logic [31:0] act;
            c = q.pop_front();
            act = pick(c.sel);
            checks++;
            if (act !== c.exp) begin
                fails++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", c.nm, act, c.exp, cyc);
            end
        end
    end

    task automatic expect_now(input string nm, input int sel, input logic [31:0] e);
        chk_t c;
        c.due = cyc; c.sel = sel; c.exp = e; c.nm = nm;
        q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_dbg = '0;
    logic [13:0] stim[$];

    // Random input stream with the first match on tick number hit_after
    // (earlier ticks forced to miss unless the mask is empty).
    task automatic build(input logic [13:0] m, input logic [13:0] v, input int d,
                         input int nint, input int hit_after);
        int L;
        L = (hit_after + nint + 3) * (d + 1);
        stim.delete();
        for (int j = 0; j < L; j++) begin
            logic [13:0] s;
            s = 14'($urandom);
            if ((j + 1) % (d + 1) == 0) begin
                int t;
                t = (j + 1) / (d + 1) - 1;
                if (t == hit_after)
                    s = (s & ~m) | (v & m);
                else if (t < hit_after && ((s ^ v) & m) == 14'd0)
                    s ^= 14'(m & (~m + 14'd1));
            end
            stim.push_back(s);
        end
    endtask

    // Reference model: walk the tick schedule over stim, derive the stored
    // shot, then drive the DUT through the same cycles and read it all back.
    task automatic run_shot(input string nm, input logic [13:0] m, input logic [13:0] v,
                            input logic [31:0] n, input int d, input int pre_req,
                            input bit do_clear, input bit arm_busy, input bit dbl_rd);
        int nint, pint, ptgt, misses, post, jdone, pe;
        bit trig;
        logic [13:0] hist[$];
        logic [13:0] es[$];
        nint = (n == 0) ? 1 : ((n > NSAMP) ? NSAMP : int'(n));
        pint = PRE_ON ? ((pre_req > nint - 1) ? nint - 1 : pre_req) : 0;
        ptgt = nint - pint;
        trig = 0; misses = 0; post = 0; jdone = -1; pe = 0;
        for (int j = 0; j < stim.size(); j++) begin
            if ((j + 1) % (d + 1) != 0) continue;
            if (!trig) begin
                if (((stim[j] ^ v) & m) == 14'd0) begin
                    trig = 1;
                    pe = (misses < pint) ? misses : pint;
                    for (int k = 0; k < pe; k++) es.push_back(hist[hist.size() - pe + k]);
                    es.push_back(stim[j]);
                    post = 1;
                end else begin
                    misses++;
                    hist.push_back(stim[j]);
                end
            end else begin
                es.push_back(stim[j]);
                post++;
            end
            if (trig && post == ptgt) begin
                jdone = j;
                break;
            end
        end
        if (jdone < 0) begin
            checks++; fails++;
            $display("FAIL %s: stimulus too short for model", nm);
            return;
        end

        if (do_clear) begin
            clr = 1'b1; step(); clr = 1'b0; exp_dbg = '0;
        end
        mask = m; val = v; nsamp = n; div = 16'(d);
`ifdef PRETRIGGER_EN
        pre_s = 32'(pre_req);
`endif
        arm = 1'b1; step(); arm = 1'b0;
        for (int j = 0; j <= jdone; j++) begin
            ins = stim[j];
            arm = arm_busy && (j == 0);
            step();
        end
        arm = 1'b0;
        if (arm_busy) exp_dbg[3] = 1'b1;
        step();
        expect_now({nm, " status"}, S_STAT, 32'd7);
        expect_now({nm, " sample_count"}, S_CNT, 32'(es.size()));
        expect_now({nm, " trig_latency"}, S_LAT, 32'(misses));
        expect_now({nm, " dbg_done"}, S_DBG, exp_dbg);
        for (int k = 0; k < es.size(); k++) begin
            expect_now($sformatf("%s read%0d", nm, k), S_RD, 32'(es[k]));
            rd = 1'b1; step();
            if (dbl_rd && k == 0) begin
                step();
                exp_dbg[0] = 1'b1;
            end
            rd = 1'b0; step();
        end
        exp_dbg[1] = 1'b1;
        expect_now({nm, " overrun_read"}, S_RD, 32'd0);
        expect_now({nm, " dbg_overrun"}, S_DBG, exp_dbg);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        expect_now("reset read_channel", S_RD, 32'd0);
        expect_now("reset sample_count", S_CNT, 32'd0);
        expect_now("reset trig_latency", S_LAT, 32'd0);
        expect_now("reset status", S_STAT, 32'd0);
        expect_now("reset dbg", S_DBG, 32'd0);
        step();

        // Counting pattern 1,2,3,4 with an empty mask.
        build(14'd0, 14'd0, 0, 4, 0);
        for (int k = 0; k < 4; k++) stim[k] = 14'(k + 1);
        run_shot("seq4", 14'd0, 14'd0, 32'd4, 0, 0, 1'b1, 1'b0, 1'b0);

        // bit0 low for 10 ticks then high; also arm while busy.
        build(14'h1, 14'h1, 0, 3, 10);
        run_shot("latency10", 14'h1, 14'h1, 32'd3, 0, 0, 1'b1, 1'b1, 1'b0);

        // clk_div=2 on a ramp aligned so the first tick sees 0.
        build(14'd0, 14'd0, 2, 3, 0);
        for (int j = 0; j < stim.size(); j++) stim[j] = 14'(j - 2);
        run_shot("div2_ramp", 14'd0, 14'd0, 32'd3, 2, 0, 1'b1, 1'b0, 1'b0);

        // Length clamping, with a held strobe on the long shot.
        build(14'd0, 14'd0, 0, NSAMP, 0);
        run_shot("n1000", 14'd0, 14'd0, 32'd1000, 0, 0, 1'b1, 1'b0, 1'b1);
        build(14'd0, 14'd0, 0, 1, 0);
        run_shot("n0", 14'd0, 14'd0, 32'd0, 0, 0, 1'b1, 1'b0, 1'b0);

        // Clear on the 5th capture tick, then re-arm without another clear.
        clr = 1'b1; step(); clr = 1'b0; exp_dbg = '0;
        build(14'h3, 14'h1, 0, 20, 3);
        mask = 14'h3; val = 14'h1; nsamp = 32'd20; div = '0;
        arm = 1'b1; step(); arm = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            ins = stim[j];
            clr = (j == 8);
            step();
        end
        clr = 1'b0;
        expect_now("clear status", S_STAT, 32'd0);
        expect_now("clear sample_count", S_CNT, 32'd0);
        expect_now("clear trig_latency", S_LAT, 32'd0);
        expect_now("clear dbg", S_DBG, 32'd0);
        expect_now("clear read_channel", S_RD, 32'd0);
        step();
        build(14'h5, 14'h4, 1, 6, 2);
        run_shot("rearm", 14'h5, 14'h4, 32'd6, 1, 0, 1'b0, 1'b0, 1'b0);

        // Strobe edge while idle: flags an error, readout holds.
        clr = 1'b1; step(); clr = 1'b0;
        rd = 1'b1; step(); rd = 1'b0; step();
        exp_dbg = 32'd4;
        expect_now("idle_strobe dbg", S_DBG, exp_dbg);
        expect_now("idle_strobe read_channel", S_RD, 32'd0);
        step();
        build(14'h20, 14'h20, 0, 5, 4);
        run_shot("after_idle_strobe", 14'h20, 14'h20, 32'd5, 0, 0, 1'b0, 1'b0, 1'b0);

`ifdef PRETRIGGER_EN
        build(14'h1, 14'h1, 0, 8, 10);
        run_shot("pre_late", 14'h1, 14'h1, 32'd8, 0, 3, 1'b1, 1'b0, 1'b0);
        build(14'd0, 14'd0, 0, 8, 0);
        run_shot("pre_first", 14'd0, 14'd0, 32'd8, 0, 3, 1'b1, 1'b0, 1'b0);
`endif

        for (int r = 0; r < 6; r++) begin
            logic [13:0] m, v;
            int d, n, h, p;
            m = 14'($urandom) & 14'($urandom);
            v = 14'($urandom);
            d = $urandom_range(0, 3);
            n = $urandom_range(0, 40);
            h = $urandom_range(0, 12);
            p = $urandom_range(0, 10);
            build(m, v, d, (n == 0) ? 1 : n, h);
            run_shot($sformatf("rand%0d", r), m, v, 32'(n), d, p, 1'($urandom_range(0, 1)),
                     1'b0, 1'b0);
        end

        repeat (3) step();
        if (q.size() != 0) begin
            checks++; fails++;
            $display("FAIL drain: %0d checks left unevaluated, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
